// File: rtl/serv_dbg_ctrl.sv
// rtl/serv_dbg_ctrl.sv - debug run-control sequencer for the SERV core
// Turns DM halt/resume, dcsr.step and ebreak into the decoder's debug-entry strobes.
module serv_dbg_ctrl #(
  parameter bit RESET_HALT = 1'b0,
  parameter int TMO_W      = 8
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_dm_haltreq,
  input  logic       i_dm_resumereq,
  input  logic       i_dcsr_step,
  input  logic       i_dcsr_ebreakm,
  input  logic       i_ibus_ack,
  input  logic       i_cnt_done,
  input  logic       i_ebreak,
  input  logic       i_dret,
  output logic       o_dbg_halt,
  output logic       o_dbg_step,
  output logic       o_dm_halted,
  output logic       o_dm_running,
  output logic       o_dm_resumeack,
  output logic [2:0] o_cause,
  output logic       o_cause_we,
  output logic       o_halt_tmo
);

  typedef enum logic [2:0] {
    S_RUN       = 3'd0,
    S_HALT_REQ  = 3'd1,
    S_ENTER     = 3'd2,
    S_HALTED    = 3'd3,
    S_RESUME    = 3'd4,
    S_STEP_EXEC = 3'd5,
    S_STEP_ARM  = 3'd6
  } state_t;

  localparam state_t           RESET_STATE = RESET_HALT ? S_HALT_REQ : S_RUN;
  localparam logic [TMO_W-1:0] TMO_LAST    = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             seen_ack_q, seen_ack_d;
  logic             dbg_halt_q, dbg_halt_d;
  logic             dbg_step_q, dbg_step_d;
  logic             dm_halted_q, dm_halted_d;
  logic             dm_running_q, dm_running_d;
  logic             resumeack_q, resumeack_d;
  logic             cause_we_q, cause_we_d;
  logic             halt_tmo_q, halt_tmo_d;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    tmo_cnt_d   = '0;
    seen_ack_d  = 1'b0;
    resumeack_d = 1'b0;
    cause_we_d  = 1'b0;
    halt_tmo_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (i_dm_haltreq) begin
          state_d = S_HALT_REQ;
        end else if (i_ebreak && i_dcsr_ebreakm && i_cnt_done) begin
          state_d = S_ENTER;
          cause_d = 3'd1;
        end
      end
      S_HALT_REQ: begin
        // Once requested, the halt stays committed even if haltreq drops.
        if (i_ibus_ack) begin
          state_d = S_ENTER;
          cause_d = 3'd3;
        end else if (tmo_cnt_q == TMO_LAST) begin
          halt_tmo_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_ENTER: begin
        if (i_cnt_done) begin
          state_d    = S_HALTED;
          cause_we_d = 1'b1;
        end
      end
      S_HALTED: begin
        if (i_dm_resumereq && !i_dm_haltreq) state_d = S_RESUME;
      end
      S_RESUME: begin
        if (i_dret && i_cnt_done) begin
          resumeack_d = 1'b1;
          state_d     = i_dcsr_step ? S_STEP_EXEC : S_RUN;
        end
      end
      S_STEP_EXEC: begin
        seen_ack_d = seen_ack_q | i_ibus_ack;
        if (i_cnt_done && (seen_ack_q || i_ibus_ack)) begin
          state_d    = S_STEP_ARM;
          seen_ack_d = 1'b0;
        end
      end
      S_STEP_ARM: begin
        if (i_ibus_ack) begin
          state_d = S_ENTER;
          cause_d = i_dm_haltreq ? 3'd3 : 3'd4;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    // Status and strobes are decoded from the next state so they line up with state_q.
    dbg_halt_d   = (state_d == S_HALT_REQ) || ((state_d == S_STEP_ARM) && i_dm_haltreq);
    dbg_step_d   = (state_d == S_STEP_ARM) && !i_dm_haltreq;
    dm_halted_d  = (state_d == S_HALTED);
    dm_running_d = (state_d == S_RUN) || (state_d == S_HALT_REQ) ||
                   (state_d == S_STEP_EXEC) || (state_d == S_STEP_ARM);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= RESET_STATE;
      cause_q      <= 3'd0;
      tmo_cnt_q    <= '0;
      seen_ack_q   <= 1'b0;
      dbg_halt_q   <= RESET_HALT;
      dbg_step_q   <= 1'b0;
      dm_halted_q  <= 1'b0;
      dm_running_q <= 1'b1;
      resumeack_q  <= 1'b0;
      cause_we_q   <= 1'b0;
      halt_tmo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      tmo_cnt_q    <= tmo_cnt_d;
      seen_ack_q   <= seen_ack_d;
      dbg_halt_q   <= dbg_halt_d;
      dbg_step_q   <= dbg_step_d;
      dm_halted_q  <= dm_halted_d;
      dm_running_q <= dm_running_d;
      resumeack_q  <= resumeack_d;
      cause_we_q   <= cause_we_d;
      halt_tmo_q   <= halt_tmo_d;
    end
  end

  assign o_dbg_halt     = dbg_halt_q;
  assign o_dbg_step     = dbg_step_q;
  assign o_dm_halted    = dm_halted_q;
  assign o_dm_running   = dm_running_q;
  assign o_dm_resumeack = resumeack_q;
  assign o_cause        = cause_q;
  assign o_cause_we     = cause_we_q;
  assign o_halt_tmo     = halt_tmo_q;

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// tb/tb_serv_dbg_ctrl.sv - directed self-checking bench for serv_dbg_ctrl
module tb_serv_dbg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       haltreq, resumereq, dstep, ebreakm, ack, cnt_done, ebreak, dret;
  logic       dbg_halt, dbg_step, halted, running, resumeack, cause_we, halt_tmo;
  logic [2:0] cause;
  logic       rh_dbg_halt, rh_dbg_step, rh_halted, rh_running, rh_resumeack, rh_cause_we, rh_halt_tmo;
  logic [2:0] rh_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serv_dbg_ctrl #(.RESET_HALT(1'b0), .TMO_W(3)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_dm_haltreq(haltreq), .i_dm_resumereq(resumereq),
    .i_dcsr_step(dstep), .i_dcsr_ebreakm(ebreakm), .i_ibus_ack(ack), .i_cnt_done(cnt_done),
    .i_ebreak(ebreak), .i_dret(dret), .o_dbg_halt(dbg_halt), .o_dbg_step(dbg_step),
    .o_dm_halted(halted), .o_dm_running(running), .o_dm_resumeack(resumeack),
    .o_cause(cause), .o_cause_we(cause_we), .o_halt_tmo(halt_tmo)
  );

  serv_dbg_ctrl #(.RESET_HALT(1'b1), .TMO_W(3)) dut_rh (
    .clk(clk), .i_rst_n(rst_n), .i_dm_haltreq(haltreq), .i_dm_resumereq(resumereq),
    .i_dcsr_step(dstep), .i_dcsr_ebreakm(ebreakm), .i_ibus_ack(ack), .i_cnt_done(cnt_done),
    .i_ebreak(ebreak), .i_dret(dret), .o_dbg_halt(rh_dbg_halt), .o_dbg_step(rh_dbg_step),
    .o_dm_halted(rh_halted), .o_dm_running(rh_running), .o_dm_resumeack(rh_resumeack),
    .o_cause(rh_cause), .o_cause_we(rh_cause_we), .o_halt_tmo(rh_halt_tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {haltreq, resumereq, dstep, ebreakm, ack, cnt_done, ebreak, dret} = '0;
    #12;
    check("rst_running", running, 1);
    check("rst_halted", halted, 0);
    check("rst_dbg_halt", dbg_halt, 0);
    check("rst_cause", cause, 0);
    check("rst_halt_rh_dbg_halt", rh_dbg_halt, 1);
    check("rst_halt_rh_running", rh_running, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Halt with ack three cycles after the request
    haltreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_strobe", dbg_halt, 1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0; haltreq = 1'b0;
    check("enter_dbg_halt", dbg_halt, 0);
    check("enter_running", running, 0);
    check("enter_halted", halted, 0);
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    check("halt_halted", halted, 1);
    check("halt_cause", cause, 3);
    check("halt_cause_we", cause_we, 1);
    tick();
    check("halt_cause_we_once", cause_we, 0);

    // Simultaneous halt and resume keeps the core halted
    haltreq = 1'b1; resumereq = 1'b1;
    tick();
    check("both_halted", halted, 1);
    haltreq = 1'b0;
    tick();
    resumereq = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_running", running, 0);
    tick();
    check("resume_no_ack", resumeack, 0);
    dret = 1'b1; cnt_done = 1'b1;
    tick();
    dret = 1'b0; cnt_done = 1'b0;
    check("resume_ack", resumeack, 1);
    check("resume_run", running, 1);
    tick();
    check("resume_ack_once", resumeack, 0);

    // ebreak ignored without ebreakm, taken with it
    ebreak = 1'b1; cnt_done = 1'b1;
    tick();
    check("ebreak_off_running", running, 1);
    ebreakm = 1'b1;
    tick();
    ebreak = 1'b0;
    check("ebreak_enter", running, 0);
    tick();
    cnt_done = 1'b0; ebreakm = 1'b0;
    check("ebreak_halted", halted, 1);
    check("ebreak_cause", cause, 1);
    check("ebreak_cause_we", cause_we, 1);

    // Single step
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0;
    dstep = 1'b1; dret = 1'b1; cnt_done = 1'b1;
    tick();
    dstep = 1'b0; dret = 1'b0;
    check("step_resumeack", resumeack, 1);
    check("step_exec_running", running, 1);
    tick();
    cnt_done = 1'b0;
    check("step_no_ack_no_arm", dbg_step, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0; cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    check("step_arm_step", dbg_step, 1);
    check("step_arm_halt", dbg_halt, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("step_enter_strobe", dbg_step, 0);
    cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    check("step_halted", halted, 1);
    check("step_cause", cause, 4);

    // Back to RUN, then watchdog timeout with TMO_W = 3
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0; dret = 1'b1; cnt_done = 1'b1;
    tick();
    dret = 1'b0; cnt_done = 1'b0;
    check("tmo_pre_running", running, 1);
    haltreq = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      check($sformatf("tmo_k%0d", k), halt_tmo, (k == 7 || k == 14) ? 1 : 0);
    end
    check("tmo_still_halt_req", dbg_halt, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0; haltreq = 1'b0; cnt_done = 1'b1;
    tick();
    cnt_done = 1'b0;
    check("tmo_halted", halted, 1);
    check("tmo_cause", cause, 3);

    // Reset pulsed during RESUME
    resumereq = 1'b1;
    tick();
    resumereq = 1'b0;
    check("rst_mid_in_resume", running, 0);
    dret = 1'b1; cnt_done = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_running", running, 1);
    check("rst_mid_resumeack", resumeack, 0);
    tick();
    check("rst_mid_resumeack_held", resumeack, 0);
    dret = 1'b0; cnt_done = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_mid_after_running", running, 1);
    check("rst_mid_after_halted", halted, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
